// File: rtl/audio_pkg.sv
// Shared audio definitions: default sample width, receiver state encoding and
// the bit-counter sizing rule.
package audio_pkg;

  localparam int I2S_SAMPLE_BITS   = 24;
  localparam int I2S_MAX_SLOT_BITS = 64;

  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    RIGHT
  } rx_state_t;

  // Counter must be able to hold MAX_SLOT_BITS itself, hence the extra bit.
  function automatic int cnt_width(input int max_slot_bits);
    return $clog2(max_slot_bits) + 1;
  endfunction

endpackage

// File: rtl/i2s_sync_edge.sv
// Synchronises LRCK/BCK/DATA into clk and emits a registered one-cycle pulse per
// BCK rising edge, with LRCK and DATA captured from the same synchronised stage.
module i2s_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic lrck,
  input  logic bck,
  input  logic data,
  output logic bck_rise,
  output logic lrck_smp,
  output logic data_smp
);

  logic [SYNC_STAGES-1:0] lrck_sync;
  logic [SYNC_STAGES-1:0] bck_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   bck_prev;
  logic                   rise_now;

  assign rise_now = bck_sync[SYNC_STAGES-1] & ~bck_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      lrck_sync <= '0;
      bck_sync  <= '0;
      data_sync <= '0;
      bck_prev  <= 1'b0;
      bck_rise  <= 1'b0;
    end else begin
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], lrck};
      bck_sync  <= {bck_sync[SYNC_STAGES-2:0], bck};
      data_sync <= {data_sync[SYNC_STAGES-2:0], data};
      bck_prev  <= bck_sync[SYNC_STAGES-1];
      bck_rise  <= rise_now;
    end
  end

  // Sample registers move only on a detected rise, so they need no reset.
  always_ff @(posedge clk) begin
    if (rise_now) begin
      lrck_smp <= lrck_sync[SYNC_STAGES-1];
      data_smp <= data_sync[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/i2s_rx.sv
// Philips I2S receiver: deserialises left/right words, tracks frame alignment
// and hands complete sample pairs to the consumer through a valid/ack handshake.
module i2s_rx
  import audio_pkg::*;
#(
  parameter int SAMPLE_BITS   = I2S_SAMPLE_BITS,
  parameter int SYNC_STAGES   = 2,
  parameter int MAX_SLOT_BITS = I2S_MAX_SLOT_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i2s_lrck,
  input  logic                   i2s_bck,
  input  logic                   i2s_data,
  output logic [SAMPLE_BITS-1:0] left_data,
  output logic [SAMPLE_BITS-1:0] right_data,
  output logic                   sample_valid,
  input  logic                   sample_ack,
  output logic                   locked,
  output logic                   overrun,
  output logic                   frame_error,
  input  logic                   status_clear
);

  localparam int               CNT_W = cnt_width(MAX_SLOT_BITS);
  localparam logic [CNT_W-1:0] SB_C  = CNT_W'(SAMPLE_BITS);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_SLOT_BITS);

  logic bck_rise_p1;
  logic lrck_p1;
  logic data_p1;

  i2s_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .lrck     (i2s_lrck),
    .bck      (i2s_bck),
    .data     (i2s_data),
    .bck_rise (bck_rise_p1),
    .lrck_smp (lrck_p1),
    .data_smp (data_p1)
  );

  rx_state_t              state;
  logic                   prev_lrck;
  logic [CNT_W-1:0]       bit_cnt;
  logic [SAMPLE_BITS-1:0] shift_reg;
  logic [SAMPLE_BITS-1:0] hold_left;

  // Short words sit MSB-aligned with zero-filled low bits.
  function automatic logic [SAMPLE_BITS-1:0] justify(input logic [SAMPLE_BITS-1:0] word,
                                                      input logic [CNT_W-1:0] n);
    if (n >= SB_C) return word;
    return word << (SB_C - n);
  endfunction

  logic lr_change;
  logic shift_bit;
  logic slot_full;
  logic frame_err_evt;
  logic publish;
  logic overrun_evt;

  assign lr_change     = bck_rise_p1 && (lrck_p1 != prev_lrck);
  assign shift_bit     = bck_rise_p1 && (lrck_p1 == prev_lrck);
  assign slot_full     = shift_bit && (state != IDLE) && (bit_cnt == MAX_C - 1'b1);
  assign frame_err_evt = (lr_change && (state != IDLE) && (bit_cnt == '0)) || slot_full;
  assign publish       = lr_change && (state == RIGHT) && (bit_cnt != '0);
  assign overrun_evt   = publish && sample_valid && !sample_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      prev_lrck    <= 1'b0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      hold_left    <= '0;
      left_data    <= '0;
      right_data   <= '0;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
      overrun      <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      if (status_clear) begin
        overrun     <= 1'b0;
        frame_error <= 1'b0;
      end
      if (overrun_evt) overrun <= 1'b1;

      if (frame_err_evt) begin
        frame_error <= 1'b1;
        locked      <= 1'b0;
        state       <= IDLE;
        hold_left   <= '0;
      end

      // A publish beats a coincident ack so the new pair is never lost.
      if (publish) begin
        left_data    <= hold_left;
        right_data   <= justify(shift_reg, bit_cnt);
        sample_valid <= 1'b1;
      end else if (sample_ack) begin
        sample_valid <= 1'b0;
      end

      if (bck_rise_p1) prev_lrck <= lrck_p1;

      if (lr_change) begin
        bit_cnt   <= '0;
        shift_reg <= '0;
        if (!frame_err_evt) begin
          case (state)
            IDLE:    if (!lrck_p1) state <= LEFT;
            LEFT: begin
              hold_left <= justify(shift_reg, bit_cnt);
              locked    <= 1'b1;
              state     <= RIGHT;
            end
            RIGHT:   state <= LEFT;
            default: state <= IDLE;
          endcase
        end
      end else if (shift_bit) begin
        if (bit_cnt < SB_C) shift_reg <= {shift_reg[SAMPLE_BITS-2:0], data_p1};
        if (bit_cnt < MAX_C) bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S receiver for audio capture; the inverse of the dacif transmitter.
- Synchronises external LRCK/BCK/DATA into the system clock and deserialises standard Philips I2S frames (MSB one BCK after the LRCK edge, LRCK low = left).
- Presents left/right sample pairs to the audio block with a valid/ack handshake.
- Sits beside pcm/dacif in the audio hierarchy and feeds a future capture FIFO.

Parameters:
- SAMPLE_BITS, 24: bits captured per channel, MSB-first, left-justified.
- SYNC_STAGES, 2: flip-flop stages on each I2S input, minimum 2.
- MAX_SLOT_BITS, 64: BCK rises per half-frame before a frame error is flagged.

Ports:
- clk  in  1  system clock; must be ≥4× BCK frequency.
- rst  in  1  synchronous, active-high reset.
- i2s_lrck  in  1  word select, asynchronous to clk.
- i2s_bck  in  1  bit clock, asynchronous to clk.
- i2s_data  in  1  serial data, asynchronous to clk.
- left_data  out  SAMPLE_BITS  captured left sample, two's complement.
- right_data  out  SAMPLE_BITS  captured right sample, two's complement.
- sample_valid  out  1  pair available; held until sample_ack.
- sample_ack  in  1  consumer accepts pair; clears sample_valid next cycle.
- locked  out  1  receiver is frame-aligned.
- overrun  out  1  sticky: a new pair arrived while sample_valid was high.
- frame_error  out  1  sticky: bad half-frame length.
- status_clear  in  1  clears overrun and frame_error.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, shift register and bit counter 0. Reset applied mid-frame discards any partial word; the receiver relocks on the next LRCK falling edge.
- Input path:
  - SYNC_STAGES flops on each input.
  - A BCK rising edge is detected when the last two synchronised BCK values are 0 then 1, giving a one-cycle pulse.
  - LRCK and DATA are sampled from the same synchronised stage on that pulse.
- Per BCK rise: compare sampled LRCK with the value sampled at the previous rise.
  - Change (LRCK edge): the data bit on this rise is discarded (LSB slot of the previous word). The previous channel's word is committed, the bit counter is reset to 0, and the channel becomes the new LRCK value.
  - No change: if bit counter < SAMPLE_BITS, shift DATA into the shift register LSB-ward (MSB first). Increment the counter, saturating at MAX_SLOT_BITS.
- Commit: a word with fewer than SAMPLE_BITS bits is left-justified and its low bits are zero-filled. Bits beyond SAMPLE_BITS are ignored.
- FSM:
  - IDLE → LEFT on an LRCK 1→0 change; no commit occurs.
  - LEFT → RIGHT on a 0→1 change; the left word is committed to a holding register and locked is set to 1.
  - RIGHT → LEFT on a 1→0 change; the right word is committed and the pair is published.
- Publish:
  - left_data and right_data update on the clk cycle after the committing BCK-edge pulse.
  - sample_valid is set in the same cycle.
  - If sample_valid was already high and not acked in that cycle, overrun is set and the outputs are overwritten with the new pair.
- Ack: sample_ack while sample_valid is high clears sample_valid on the next cycle. If ack and publish coincide, the publish wins: sample_valid stays 1, new data is presented, and no overrun is raised.
- Frame error (either case):
  - Triggers: bit counter reaches MAX_SLOT_BITS with no LRCK change, or an LRCK change arrives with bit counter < 1 (empty word).
  - Action: set frame_error, clear locked, go to IDLE, and discard the holding register. No pair is published.
- status_clear clears the sticky flags. If it coincides with a new error or overrun event, the event wins.
- Latency: from the BCK rise that commits the right word to sample_valid is SYNC_STAGES+2 clk cycles.

Decomposition:
- Shared audio_pkg:
  - I2S_SAMPLE_BITS default constant.
  - rx_state_t enum {IDLE, LEFT, RIGHT}.
  - Bit-counter width constant, $clog2(MAX_SLOT_BITS)+1.
- One sub-module, i2s_sync_edge: parametrised synchroniser for the three inputs plus the BCK rising-edge pulse generator.
- Deserialiser, FSM, holding register and handshake live in i2s_rx.

Test Plan:
- 32-BCK slots. Send left 0x123456 and right 0xABCDEF (8 trailing zero bits per slot), preceded by one alignment frame → sample_valid rises SYNC_STAGES+2 cycles after the right commit edge; left_data=0x123456, right_data=0xABCDEF, locked=1.
- 16-bit words in 17-BCK slots, left 0x8001, right 0x7FFF → left_data=0x800100, right_data=0x7FFF00, no frame_error.
- Two consecutive pairs with sample_ack never asserted → overrun=1; outputs hold the second pair. status_clear → overrun=0.
- LRCK held low for 70 BCK after lock → frame_error=1, locked=0, no publish. A subsequent valid frame relocks; frame_error stays 1 until status_clear.
- Assert rst for one cycle mid-left-word → all outputs 0. The next full frame after an LRCK falling edge is captured correctly.
- sample_ack pulsed in the same cycle as a new publish → sample_valid remains 1, new data is visible, overrun=0.
